// File: rtl/adc_pkg.sv
// Shared ADC definitions: sample resolution, frame marker bits and the packer FSM states.
package adc_pkg;

    localparam int unsigned ADC_RES = 12;
    localparam int unsigned FIELD_W = ADC_RES / 2;

    // Bit 7 set only on the first byte lets the host resynchronise after a lost byte.
    localparam logic [1:0] MARK_HI = 2'b10;
    localparam logic [1:0] MARK_LO = 2'b00;

    typedef enum logic [1:0] {
        IDLE,
        SEND_HI,
        SEND_LO
    } pack_state_t;

    function automatic logic [7:0] frame_hi(input logic [ADC_RES-1:0] s);
        return {MARK_HI, s[ADC_RES-1:FIELD_W]};
    endfunction

    function automatic logic [7:0] frame_lo(input logic [FIELD_W-1:0] f);
        return {MARK_LO, f};
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational read data: pop_data is valid whenever empty is low.
module sync_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             do_push;
    logic             do_pop;

    assign full     = (level_q == LVL_W'(DEPTH));
    assign empty    = (level_q == '0);
    assign level    = level_q;
    assign pop_data = mem[rd_ptr_q];

    // A full FIFO still takes a write when a slot is freed in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/adc_sample_packer.sv
// Buffers ADC samples and emits each as a two-byte self-synchronising frame on a byte stream.
module adc_sample_packer
    import adc_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic [ADC_RES-1:0]            sample_data,
    output logic [7:0]                    tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    input  logic                          clear_overflow,
    output logic [CNT_W-1:0]              drop_count
);

    pack_state_t          state_q;
    logic [FIELD_W-1:0]   hold_q;
    logic [ADC_RES-1:0]   fifo_rd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 fifo_pop;
    logic                 drop;

    sync_fifo #(
        .WIDTH (ADC_RES),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (sample_valid),
        .push_data (sample_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    always_comb begin
        fifo_pop = 1'b0;
        if (!fifo_empty) begin
            fifo_pop = (state_q == IDLE) || ((state_q == SEND_LO) && tx_ready);
        end
    end

    assign drop = sample_valid && fifo_full && !fifo_pop;

    // Only the low field is kept; the high field already sits in tx_data as byte0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        hold_q   <= fifo_rd[FIELD_W-1:0];
                        tx_data  <= frame_hi(fifo_rd);
                        tx_valid <= 1'b1;
                        state_q  <= SEND_HI;
                    end
                end
                SEND_HI: begin
                    if (tx_ready) begin
                        tx_data <= frame_lo(hold_q);
                        state_q <= SEND_LO;
                    end
                end
                SEND_LO: begin
                    if (tx_ready) begin
                        if (!fifo_empty) begin
                            hold_q  <= fifo_rd[FIELD_W-1:0];
                            tx_data <= frame_hi(fifo_rd);
                            state_q <= SEND_HI;
                        end else begin
                            tx_valid <= 1'b0;
                            tx_data  <= '0;
                            state_q  <= IDLE;
                        end
                    end
                end
                default: begin
                    tx_valid <= 1'b0;
                    tx_data  <= '0;
                    state_q  <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear_overflow) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_adc_sample_packer.sv
// Scoreboard bench for adc_sample_packer: directed frame/overflow/reset cases plus random traffic.
module tb_adc_sample_packer;

    localparam int DEPTH = 16;

    logic        clock;
    logic        reset;
    logic        sample_valid;
    logic [11:0] sample_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        clear_overflow;
    logic [15:0] drop_count;

    int          vectors = 0;
    int          errors = 0;
    logic [7:0]  exp_q[$];
    bit          random_phase = 0;
    int          outstanding = 0;

    adc_sample_packer #(
        .FIFO_DEPTH (DEPTH),
        .CNT_W      (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .sample_valid   (sample_valid),
        .sample_data    (sample_data),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .clear_overflow (clear_overflow),
        .drop_count     (drop_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic logic [7:0] m_hi(input int s);
        return 8'(128 + s / 64);
    endfunction

    function automatic logic [7:0] m_lo(input int s);
        return 8'(s % 64);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_sample(input logic [11:0] s, input bit expect_out);
        sample_valid = 1'b1;
        sample_data  = s;
        if (expect_out) begin
            exp_q.push_back(m_hi(int'(s)));
            exp_q.push_back(m_lo(int'(s)));
        end
        step();
        sample_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) step();
        check(name, exp_q.size(), 0);
        step();
        step();
    endtask

    // Monitor: every accepted byte is popped from the scoreboard and compared.
    always @(negedge clock) begin
        if (!reset && tx_valid && tx_ready) begin
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL unexpected_byte: got 0x%0h, expected no byte", tx_data);
            end else begin
                check("tx_byte", tx_data, exp_q.pop_front());
            end
            if (random_phase && !tx_data[7] && outstanding > 0) outstanding--;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int run;
        int stable;
        int found;
        int remaining;
        logic [7:0] held;

        reset          = 1'b1;
        sample_valid   = 1'b0;
        sample_data    = '0;
        tx_ready       = 1'b1;
        clear_overflow = 1'b0;
        step();
        step();
        step();
        reset = 1'b0;
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_count", drop_count, 0);
        step();

        // Single sample latency
        push_sample(12'hABC, 1'b1);
        check("single_level_n1", fifo_level, 1);
        check("single_valid_n1", tx_valid, 0);
        step();
        check("single_valid_n2", tx_valid, 1);
        check("single_byte0", tx_data, 8'hAA);
        step();
        check("single_byte1", tx_data, 8'h3C);
        step();
        check("single_idle", tx_valid, 0);
        check("single_level_end", fifo_level, 0);

        // Back-to-back stream with no gaps
        fork
            begin
                push_sample(12'h000, 1'b1);
                push_sample(12'hFFF, 1'b1);
                push_sample(12'h800, 1'b1);
                push_sample(12'h03F, 1'b1);
                push_sample(12'hFC0, 1'b1);
            end
            begin
                for (int i = 0; i < 10 && !tx_valid; i++) step();
                run = 0;
                while (tx_valid && run < 40) begin
                    run++;
                    step();
                end
                check("stream_run", run, 10);
            end
        join
        drain("stream_drain", 50);

        // Stall during byte1
        push_sample(12'h5A5, 1'b1);
        push_sample(12'h123, 1'b1);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (tx_valid && !tx_data[7]) begin
                found = 1;
                break;
            end
            step();
        end
        check("stall_found_byte1", found, 1);
        tx_ready = 1'b0;
        held = tx_data;
        check("stall_held_byte", held, m_lo(12'h5A5));
        stable = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (tx_valid && tx_data == held) stable++;
        end
        check("stall_stable_cycles", stable, 20);
        tx_ready = 1'b1;
        drain("stall_drain", 50);

        // Overflow: one frame stalled in SEND_HI, then 20 pushes into 16 slots
        tx_ready = 1'b0;
        push_sample(12'h111, 1'b1);
        step();
        for (int i = 0; i < 20; i++) push_sample(12'($urandom_range(0, 4095)), i < 16);
        check("ovf_level", fifo_level, 16);
        check("ovf_flag", overflow, 1);
        check("ovf_drop_count", drop_count, 4);
        tx_ready = 1'b1;
        step();
        check("ovf_in_send_lo", {tx_valid, tx_data[7]}, 2'b10);
        push_sample(12'h7E7, 1'b1);
        check("full_pushpop_level", fifo_level, 16);
        check("full_pushpop_drops", drop_count, 4);
        tx_ready       = 1'b0;
        sample_valid   = 1'b1;
        sample_data    = 12'h555;
        clear_overflow = 1'b1;
        step();
        sample_valid   = 1'b0;
        clear_overflow = 1'b0;
        check("clear_wins_flag", overflow, 0);
        check("clear_wins_count", drop_count, 0);
        check("clear_wins_level", fifo_level, 16);
        tx_ready = 1'b1;
        drain("ovf_drain", 200);

        // Reset during SEND_LO with 3 samples buffered
        tx_ready = 1'b0;
        push_sample(12'h0A1, 1'b1);
        push_sample(12'h0B2, 1'b1);
        push_sample(12'h0C3, 1'b1);
        push_sample(12'h0D4, 1'b1);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        step();
        check("rst_mid_level", fifo_level, 3);
        check("rst_mid_send_lo", {tx_valid, tx_data}, {1'b1, m_lo(12'h0A1)});
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_valid_async", tx_valid, 0);
        exp_q.delete();
        step();
        reset    = 1'b0;
        tx_ready = 1'b1;
        check("rst_mid_level_after", fifo_level, 0);
        run = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (tx_valid) run++;
        end
        check("rst_mid_no_output", run, 0);

        // Random traffic, pushes throttled so nothing is ever dropped
        random_phase = 1;
        outstanding  = 0;
        remaining    = 300;
        for (int cyc = 0; cyc < 20000 && remaining > 0; cyc++) begin
            tx_ready = ($urandom_range(0, 9) < 7);
            if (outstanding < DEPTH && $urandom_range(0, 3) == 0) begin
                sample_valid = 1'b1;
                sample_data  = 12'($urandom_range(0, 4095));
                exp_q.push_back(m_hi(int'(sample_data)));
                exp_q.push_back(m_lo(int'(sample_data)));
                outstanding++;
                remaining--;
            end else begin
                sample_valid = 1'b0;
            end
            step();
        end
        sample_valid = 1'b0;
        tx_ready     = 1'b1;
        check("rand_all_pushed", remaining, 0);
        drain("rand_drain", 200);
        check("rand_overflow", overflow, 0);
        check("rand_drop_count", drop_count, 0);
        check("rand_level", fifo_level, 0);
        check("rand_idle", tx_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
